// File: rtl/sfft_buffer_sequencer.sv
// Address/enable sequencer for one in-place radix-2 FFT frame held in a dual-port RAM:
// bit-reversed load, per-butterfly read/wait/write-back over all stages, natural-order unload.
module sfft_buffer_sequencer #(
  parameter int unsigned N_LOG2       = 9,
  parameter int unsigned BFLY_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [N_LOG2-1:0]           address_A,
  output logic [N_LOG2-1:0]           address_B,
  output logic                        writeEnable_A,
  output logic                        writeEnable_B,
  output logic                        wr_src,
  output logic                        bfly_valid,
  output logic [$clog2(N_LOG2+1)-1:0] bfly_stage,
  output logic [N_LOG2-2:0]           k_index,
  output logic                        out_valid,
  output logic [N_LOG2-1:0]           out_index
);

  localparam int unsigned AW   = N_LOG2;
  localparam int unsigned KW   = N_LOG2 - 1;
  localparam int unsigned SW   = $clog2(N_LOG2 + 1);
  localparam int unsigned CW   = N_LOG2 + 1;
  localparam int unsigned WW   = 4;
  localparam int unsigned NPTS = 1 << N_LOG2;

  localparam logic [CW-1:0] LOAD_LAST   = CW'(NPTS - 1);
  localparam logic [CW-1:0] UNLOAD_LAST = CW'(NPTS);
  localparam logic [KW-1:0] J_LAST      = KW'(NPTS / 2 - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(N_LOG2 - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(BFLY_LATENCY - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RD     = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_WR     = 3'd4;
  localparam logic [2:0] ST_UNLOAD = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] j_q, j_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          bfly_valid_d;
  logic          out_valid_d;
  logic [AW-1:0] out_index_d;
  logic          done_d;

  logic [AW-1:0] load_addr;
  logic [AW-1:0] j_ext;
  logic [AW-1:0] half;
  logic [AW-1:0] pos;
  logic [AW-1:0] bf_a;
  logic [AW-1:0] bf_b;
  logic [KW-1:0] bf_k;

  // Load address is the bit-reversed sample count.
  always_comb begin
    load_addr = '0;
    for (int i = 0; i < int'(AW); i++) begin
      load_addr[i] = cnt_q[AW-1-i];
    end
  end

  // Butterfly operand pair and twiddle index for stage s_q, butterfly j_q.
  assign j_ext = AW'(j_q);
  assign half  = AW'(1) << s_q;
  assign pos   = j_ext & (half - AW'(1));
  assign bf_a  = ((j_ext >> s_q) << (s_q + SW'(1))) | pos;
  assign bf_b  = bf_a + half;
  assign bf_k  = KW'(pos << (SW'(N_LOG2 - 1) - s_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s_q        <= '0;
      j_q        <= '0;
      wait_q     <= '0;
      bfly_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      j_q        <= j_d;
      wait_q     <= wait_d;
      bfly_valid <= bfly_valid_d;
      out_valid  <= out_valid_d;
      out_index  <= out_index_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    s_d           = s_q;
    j_d           = j_q;
    wait_d        = wait_q;
    bfly_valid_d  = 1'b0;
    out_valid_d   = 1'b0;
    out_index_d   = '0;
    done_d        = 1'b0;
    busy          = (state_q != ST_IDLE);
    sample_ready  = 1'b0;
    address_A     = '0;
    address_B     = '0;
    writeEnable_A = 1'b0;
    writeEnable_B = 1'b0;
    wr_src        = 1'b0;
    bfly_stage    = '0;
    k_index       = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end

      ST_LOAD: begin
        sample_ready = 1'b1;
        address_A    = load_addr;
        if (sample_valid) begin
          writeEnable_A = 1'b1;
          if (cnt_q == LOAD_LAST) begin
            state_d = ST_RD;
            cnt_d   = '0;
            s_d     = '0;
            j_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_RD: begin
        address_A    = bf_a;
        address_B    = bf_b;
        bfly_stage   = s_q;
        k_index      = bf_k;
        bfly_valid_d = 1'b1;
        wait_d       = '0;
        state_d      = (BFLY_LATENCY == 0) ? ST_WR : ST_WAIT;
      end

      ST_WAIT: begin
        address_A  = bf_a;
        address_B  = bf_b;
        bfly_stage = s_q;
        k_index    = bf_k;
        if (wait_q == WAIT_LAST) begin
          state_d = ST_WR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      // Write-back, then advance butterfly/stage; the last butterfly hands over to unload.
      ST_WR: begin
        address_A     = bf_a;
        address_B     = bf_b;
        bfly_stage    = s_q;
        k_index       = bf_k;
        writeEnable_A = 1'b1;
        writeEnable_B = 1'b1;
        wr_src        = 1'b1;
        state_d       = ST_RD;
        if (j_q == J_LAST) begin
          j_d = '0;
          if (s_q == S_LAST) begin
            s_d     = '0;
            cnt_d   = '0;
            state_d = ST_UNLOAD;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          j_d = j_q + KW'(1);
        end
      end

      // N reads at cnt 0..N-1, plus one trailing cycle that presents the last bin.
      ST_UNLOAD: begin
        if (cnt_q == UNLOAD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          address_A   = cnt_q[AW-1:0];
          out_valid_d = 1'b1;
          out_index_d = cnt_q[AW-1:0];
          done_d      = (cnt_q == LOAD_LAST);
          cnt_d       = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
